// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control encodings and pipeline sizing helper
package alu_pkg;
  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    ADC = 2'b10,
    SBC = 2'b11
  } op_e;
  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction
endpackage

// File: rtl/add_chunk.sv
// add_chunk: combinational W-bit adder slice exposing carry-out and carry into its top bit
module add_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  // carry into the top bit recovered from the top bit's own sum
  assign c_msb = a[W-1] ^ b[W-1] ^ sum[W-1];
endmodule

// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined WIDTH-bit add/subtract, one carry-chained chunk per stage with valid/ready flow control
module pipe_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       ctrl,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int C = chunk_w(WIDTH, STAGES);
  localparam int L = STAGES - 1;
  if (STAGES < 1 || STAGES > WIDTH || WIDTH % STAGES != 0) begin : g_bad_cfg
    $error("pipe_addsub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end
  op_e                          op;
  logic                         all_v;
  logic [STAGES-1:0]            v_q, c_q, en, src_v, src_c, ch_co, ch_cm;
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q, src_a, src_b, src_s, s_d;
  logic [STAGES-1:0][C-1:0]     ch_s;
  logic                         ovf_q, zero_q;
  assign op = op_e'(ctrl);
  // a stage may advance if it is empty or every stage below it can drain
  always_comb begin
    all_v = 1'b1;
    en    = '0;
    for (int k = L; k >= 0; k--) begin
      all_v = all_v & v_q[k];
      en[k] = out_ready | !all_v;
    end
  end
  assign in_ready = en[0] & !flush;
  always_comb begin
    src_a    = '0;
    src_b    = '0;
    src_c    = '0;
    src_s    = '0;
    src_v    = '0;
    src_a[0] = a;
    src_b[0] = (op == SUB || op == SBC) ? ~b : b;
    src_c[0] = (op == ADC || op == SBC) ? cin : ctrl[0];
    src_v[0] = in_valid & in_ready;
    for (int k = 1; k <= L; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_c[k] = c_q[k-1];
      src_s[k] = s_q[k-1];
      src_v[k] = v_q[k-1];
    end
  end
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    add_chunk #(.W(C)) u_add (
      .a    (src_a[i][i*C +: C]),
      .b    (src_b[i][i*C +: C]),
      .cin  (src_c[i]),
      .sum  (ch_s[i]),
      .cout (ch_co[i]),
      .c_msb(ch_cm[i])
    );
  end
  always_comb begin
    s_d = src_s;
    for (int k = 0; k <= L; k++) s_d[k][k*C +: C] = ch_s[k];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      for (int k = 0; k <= L; k++) begin
        if (flush || en[k]) v_q[k] <= src_v[k] & !flush;
        if (en[k] && src_v[k] && !flush) begin
          a_q[k] <= src_a[k];
          b_q[k] <= src_b[k];
          s_q[k] <= s_d[k];
          c_q[k] <= ch_co[k];
        end
      end
      if (en[L] && src_v[L] && !flush) begin
        ovf_q  <= ch_cm[L] ^ ch_co[L];
        zero_q <= s_d[L] == '0;
      end
    end
  end
  assign out_valid = v_q[L];
  assign res       = s_q[L];
  assign cout      = c_q[L];
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: directed vectors and handshake sequences across STAGES = 4, 1 and 8
module tb_pipe_addsub;
  import alu_pkg::*;
  typedef struct {
    logic [1:0]  op;
    logic        ci;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [1:0]  ctrl = 2'b00;
  logic [2:0]  ir, ov, co, of, zr;
  logic [2:0][31:0] rs;
  int n_cmp = 0, n_bad = 0;
  int lat[3] = '{4, 1, 8};
  vec_t vt[14];
  always #5 clk = ~clk;
  pipe_addsub #(.WIDTH(32), .STAGES(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a), .b(b), .ctrl(ctrl), .cin(cin), .out_valid(ov[0]), .out_ready(out_ready),
    .res(rs[0]), .cout(co[0]), .ovf(of[0]), .zero(zr[0]));
  pipe_addsub #(.WIDTH(32), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .a(a), .b(b), .ctrl(ctrl), .cin(cin), .out_valid(ov[1]), .out_ready(out_ready),
    .res(rs[1]), .cout(co[1]), .ovf(of[1]), .zero(zr[1]));
  pipe_addsub #(.WIDTH(32), .STAGES(8)) u_s8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .a(a), .b(b), .ctrl(ctrl), .cin(cin), .out_valid(ov[2]), .out_ready(out_ready),
    .res(rs[2]), .cout(co[2]), .ovf(of[2]), .zero(zr[2]));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_res/dut%0d", d), rs[d], 32'h0);
      chk($sformatf("rst_vcoz/dut%0d", d), {28'h0, ov[d], co[d], of[d], zr[d]}, 32'h0);
    end
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {29'h0, ir}, 32'h7);
  endtask
  initial begin
    int idx, got;
    vt[0]  = '{ADD, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[1]  = '{ADD, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{SUB, 1'b0, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{SBC, 1'b0, 32'h00000010, 32'h00000001, 32'h0000000E, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{ADD, 1'b0, 32'h0FFFFFFF, 32'h00000001, 32'h10000000, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{ADC, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[6]  = '{SUB, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vt[7]  = '{SUB, 1'b0, 32'h00001234, 32'h00001234, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[8]  = '{ADC, 1'b1, 32'h0000FFFF, 32'h0000FFFF, 32'h0001FFFF, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{ADD, 1'b1, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1'b0, 1'b0};
    vt[10] = '{SUB, 1'b0, 32'h0000000A, 32'h00000003, 32'h00000007, 1'b1, 1'b0, 1'b0};
    vt[11] = '{SBC, 1'b0, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vt[12] = '{ADD, 1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1};
    vt[13] = '{ADC, 1'b0, 32'h00000005, 32'h00000007, 32'h0000000C, 1'b0, 1'b0, 1'b0};
    do_reset();
    // single beats: each DUT must show the result exactly at its own latency
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      ctrl = vt[i].op; cin = vt[i].ci; a = vt[i].a; b = vt[i].b; in_valid = 1'b1;
      for (int c = 1; c <= 9; c++) begin
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
          chk($sformatf("vec%0d_valid_c%0d/dut%0d", i, c, d), {31'h0, ov[d]}, {31'h0, c == lat[d]});
          if (c == lat[d]) begin
            chk($sformatf("vec%0d_res/dut%0d", i, d), rs[d], vt[i].r);
            chk($sformatf("vec%0d_flags/dut%0d", i, d), {29'h0, co[d], of[d], zr[d]},
                {29'h0, vt[i].co, vt[i].ov, vt[i].z});
          end
        end
      end
    end
    // back-to-back stream at full throughput
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      in_valid = c < 8; ctrl = ADD; cin = 1'b0; a = 32'(c); b = 32'(c); out_ready = 1'b1;
      #1;
      chk($sformatf("stream_in_ready_c%0d", c), {29'h0, ir}, 32'h7);
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("stream_valid_c%0d/dut%0d", c, d), {31'h0, ov[d]},
            {31'h0, c >= lat[d] && c < lat[d] + 8});
        if (c >= lat[d] && c < lat[d] + 8)
          chk($sformatf("stream_res_c%0d/dut%0d", c, d), rs[d], 32'(2 * (c - lat[d])));
      end
    end
    // backpressure on the 4-stage pipe: six stalled cycles, then drain
    do_reset();
    idx = 0; got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      out_ready = c >= 6; in_valid = idx < 8; ctrl = ADD; a = 32'(idx + 1); b = 32'(idx + 1);
      #1;
      if (c == 3) chk("bp_ready_before_full", {31'h0, ir[0]}, 32'h1);
      if (c == 4 || c == 5) begin
        chk($sformatf("bp_ready_full_c%0d", c), {31'h0, ir[0]}, 32'h0);
        chk($sformatf("bp_hold_valid_c%0d", c), {31'h0, ov[0]}, 32'h1);
        chk($sformatf("bp_hold_res_c%0d", c), rs[0], 32'h2);
      end
      if (c == 6) chk("bp_full_in_and_out", {31'h0, ir[0]}, 32'h1);
      if (ov[0] && out_ready) begin
        chk($sformatf("bp_res%0d", got), rs[0], 32'(2 * (got + 1)));
        got++;
      end
      if (in_valid && ir[0]) idx++;
    end
    chk("bp_results_count", 32'(got), 32'd8);
    chk("bp_beats_sent", 32'(idx), 32'd8);
    in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("bp_no_dup_c%0d", c), {31'h0, ov[0]}, 32'h0);
    end
    // flush with three beats in flight; the beat offered during flush is dropped
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      out_ready = 1'b1; flush = c == 3; in_valid = c <= 4; ctrl = ADD;
      a = (c == 4) ? 32'h55 : 32'(100 + c);
      b = (c == 4) ? 32'h11 : 32'h0;
      #1;
      if (c == 3) chk("flush_in_ready", {29'h0, ir}, 32'h0);
      if (c >= 3) begin
        chk($sformatf("flush_valid_c%0d/dut0", c), {31'h0, ov[0]}, {31'h0, c == 8});
        chk($sformatf("flush_valid_c%0d/dut2", c), {31'h0, ov[2]}, {31'h0, c == 12});
        if (c == 8) chk("flush_next_res/dut0", rs[0], 32'h66);
        if (c == 12) chk("flush_next_res/dut2", rs[2], 32'h66);
      end
      if (c >= 4) begin
        chk($sformatf("flush_valid_c%0d/dut1", c), {31'h0, ov[1]}, {31'h0, c == 5});
        if (c == 5) chk("flush_next_res/dut1", rs[1], 32'h66);
      end
    end
    flush = 1'b0; in_valid = 1'b0;
    // asynchronous reset in the middle of a stream
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      in_valid = 1'b1; ctrl = ADD; a = 32'(c + 1); b = 32'(c + 1); out_ready = 1'b1;
      #1;
    end
    chk("areset_pre_valid/dut0", {31'h0, ov[0]}, 32'h1);
    chk("areset_pre_res/dut0", rs[0], 32'h6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", {29'h0, ov}, 32'h0);
    for (int d = 0; d < 3; d++) chk($sformatf("areset_res/dut%0d", d), rs[d], 32'h0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("areset_no_partial_c%0d", c), {29'h0, ov}, 32'h0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
- Parametrised, pipelined successor to the single-cycle 32-bit ripple adder in the ALU.
- Splits a WIDTH-bit add/subtract into STAGES equal carry-chained chunks, one chunk per pipeline stage, with a per-stage valid bit and valid/ready backpressure.
- Adds carry-in (ADC/SBC) modes and carry/overflow/zero flags.
- Sits between the decode/operand-fetch stage and the ALU result mux for multi-cycle wide arithmetic.

Parameters:
- WIDTH, 32: operand/result width; must be divisible by STAGES.
- STAGES, 4: pipeline depth and chunk count; CHUNK = WIDTH/STAGES bits per stage; 1 <= STAGES <= WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all in-flight operations.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ctrl  in  2  ctrl[0]=subtract (invert B); ctrl[1]=carry-in source select (0: carry-in = ctrl[0]; 1: carry-in = cin).
- cin  in  1  external carry-in, used only when ctrl[1]=1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- res  out  WIDTH  sum.
- cout  out  1  carry out of MSB (for subtract: 1 = no borrow).
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  out  1  res == 0.

Behaviour:
- Reset (rst_n low, async): all stage valid bits clear. out_valid=0; res, cout, ovf, zero = 0. in_ready is 1 once rst_n is high.
- Operation: B' = ctrl[0] ? ~b : b. c0 = ctrl[1] ? cin : ctrl[0]. Result = a + B' + c0, computed modulo 2^WIDTH.
  - The four ctrl encodings: 00 ADD, 01 SUB, 10 ADC, 11 SBC (SBC = a + ~b + cin).
- Stage k (0..STAGES-1) adds chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1, LSB chunk first) using the carry registered by stage k-1 (stage 0 uses c0).
- Each stage register holds:
  - the completed lower sum bits;
  - the not-yet-consumed upper operand bits (B already inverted);
  - the carry;
  - a valid bit.
- Last stage computes the MSB carry-in and carry-out for ovf, and computes zero from the full sum.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1; outputs are registered from the last stage. Throughput is one beat per cycle when out_ready=1.
- Handshake:
  - Stage advance enable: en[last] = !v[last] | out_ready; en[k] = !v[k] | en[k+1]. Bubbles collapse.
  - in_ready = en[0], combinational from out_ready and the valid bits; there is no combinational path from in_valid.
  - Transfer in when in_valid & in_ready. Transfer out when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, res/cout/ovf/zero hold stable.
  - in_valid may drop without waiting for in_ready; a beat is only captured on a transfer.
- Full: all STAGES valid and out_ready=0 -> in_ready=0; nothing moves.
- Simultaneous out transfer and in transfer when full: both occur in the same cycle; no bubble is inserted.
- flush=1: all valid bits clear at the next edge, and in_ready=0 for that cycle. The input beat is dropped and no result is produced. flush dominates in_valid.
- Reset mid-operation: all in-flight beats are discarded immediately; no partial result is ever emitted.
- STAGES=1: purely combinational sum into a single output register; latency 1 cycle.
- Data registers may be left unreset except the outputs listed above. Valid bits must be reset.

Decomposition:
- Shared package alu_pkg holds:
  - ctrl encodings ADD=2'b00, SUB=2'b01, ADC=2'b10, SBC=2'b11;
  - a localparam function for CHUNK.
- One sub-module, add_chunk: combinational CHUNK-bit ripple adder (inputs a, b, cin; outputs sum, cout, c_msb = carry into top bit). It is instanced once per stage via generate; c_msb is used only in the last stage.
- Pipeline registers and handshake live in pipe_addsub.

Test Plan (WIDTH=32, STAGES=4 unless noted):
- ADD 0xFFFFFFFF + 0x00000001, ctrl=00 -> after 4 edges: res=0x00000000, cout=1, ovf=0, zero=1.
- ADD 0x7FFFFFFF + 0x00000001 -> res=0x80000000, cout=0, ovf=1, zero=0.
- SUB 5 - 7, ctrl=01 -> res=0xFFFFFFFE, cout=0, ovf=0. SBC 0x10 - 0x01 with cin=0, ctrl=11 -> res=0x0000000E, cout=1.
- Stream of 8 back-to-back ADDs (a=i, b=i):
  - with out_ready=1: results 0, 2, ..., 14 on consecutive cycles.
  - then hold out_ready=0 for 6 cycles: in_ready falls once 4 beats are buffered; res holds; no loss or duplication after release.
- flush asserted with 3 beats in flight -> out_valid stays 0; the next accepted beat emerges with correct value and latency 4.
- rst_n pulsed low mid-stream -> out_valid=0 and res=0 immediately (async). Repeat with STAGES=1 and STAGES=8 (CHUNK=4) using the carry-chain value 0x0FFFFFFF + 1 = 0x10000000.
